ir_nec_decode: RTL

IR_NEC_DECODE -- requirements
Module: ir_nec_decode

---
 rtl/ir_pkg.sv | 39 +++
 rtl/ir_run_len.sv | 41 ++++
 rtl/ir_nec_decode.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC infrared decoder: FSM states, error codes,
// default run-length tolerances and a range-check helper.
package ir_pkg;

   typedef enum logic [3:0] {
      IDLE, SKIP, LMARK, LSPACE, BMARK, BSPACE, STOP, CHECK, OUT
   } state_t;

   localparam logic [2:0] ERR_OK     = 3'd0;
   localparam logic [2:0] ERR_EMPTY  = 3'd1;
   localparam logic [2:0] ERR_LEADER = 3'd2;
   localparam logic [2:0] ERR_TIMING = 3'd3;
   localparam logic [2:0] ERR_TRUNC  = 3'd4;
   localparam logic [2:0] ERR_CHKSUM = 3'd5;

   localparam int RUN_W = 5;

   localparam int LEAD_MIN_DEF = 12;
   localparam int LEAD_MAX_DEF = 20;
   localparam int SPN_MIN_DEF  = 6;
   localparam int SPN_MAX_DEF  = 10;
   localparam int SPR_MIN_DEF  = 3;
   localparam int SPR_MAX_DEF  = 5;

   // Bit-level timing in chips: mark, short space (0), long space (1), stop mark.
   localparam int BMARK_MIN = 1;
   localparam int BMARK_MAX = 2;
   localparam int BIT0_MIN  = 1;
   localparam int BIT0_MAX  = 2;
   localparam int BIT1_MIN  = 3;
   localparam int BIT1_MAX  = 4;
   localparam int STOP_MIN  = 1;
   localparam int STOP_MAX  = 2;

   function automatic logic in_range(input logic [RUN_W-1:0] len, input int lo, input int hi);
      return (int'(len) >= lo) && (int'(len) <= hi);
   endfunction

endpackage

// File: rtl/ir_run_len.sv
// Run-length meter: tracks the value and saturating length of the current chip run and
// strobes when an incoming chip differs, exposing the length of the run just completed.
module ir_run_len
   import ir_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   input  logic             i_adv,
   input  logic             i_chip,
   output logic [RUN_W-1:0] o_len,
   output logic             o_val,
   output logic             o_end
);

   logic             r_val;
   logic [RUN_W-1:0] r_len;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_val <= 1'b0;
         r_len <= '0;
      end else if (i_start) begin
         r_val <= 1'b0;
         r_len <= '0;
      end else if (i_adv) begin
         if (i_chip != r_val) begin
            r_val <= i_chip;
            r_len <= RUN_W'(1);
         end else if (r_len != '1) begin
            r_len <= r_len + RUN_W'(1);
         end
      end
   end

   assign o_end = i_adv && (i_chip != r_val);
   assign o_len = r_len;
   assign o_val = r_val;

endmodule

// File: rtl/ir_nec_decode.sv
// NEC frame decoder: scans a captured chip frame MSB-first, measures mark/space runs,
// decodes data or repeat frames and presents the result under a valid/ready handshake.
module ir_nec_decode
   import ir_pkg::*;
#(
   parameter int FRAME_W  = 160,
   parameter int LEAD_MIN = LEAD_MIN_DEF,
   parameter int LEAD_MAX = LEAD_MAX_DEF,
   parameter int SPN_MIN  = SPN_MIN_DEF,
   parameter int SPN_MAX  = SPN_MAX_DEF,
   parameter int SPR_MIN  = SPR_MIN_DEF,
   parameter int SPR_MAX  = SPR_MAX_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               enable,
   input  logic               frame_valid,
   input  logic [FRAME_W-1:0] frame,
   output logic               busy,
   output logic               overrun,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        addr,
   output logic [7:0]         cmd,
   output logic               addr_ext,
   output logic               rpt,
   output logic [2:0]         err
);

   localparam int CNT_W = $clog2(FRAME_W + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_fv_d;
   logic [FRAME_W-1:0] r_sr;
   logic [CNT_W-1:0]   r_left;
   logic [31:0]        r_data;
   logic [5:0]         r_nbits;
   logic               r_is_rpt;
   logic               r_overrun;
   logic [15:0]        r_addr;
   logic [7:0]         r_cmd;
   logic               r_ext;
   logic               r_rpt;
   logic [2:0]         r_err;

   logic               w_fv_rise;
   logic               w_start;
   logic               w_chip;
   logic               w_adv;
   logic               w_run_end;
   logic               w_run_val;
   logic [RUN_W-1:0]   w_run_len;
   logic               w_bit_vld;
   logic               w_bit;
   logic               w_set_rpt;
   logic               w_load;
   logic               w_upd;
   logic [2:0]         w_code;

   assign w_fv_rise = frame_valid & ~r_fv_d;
   assign w_start   = (r_state == IDLE) && w_fv_rise;
   assign w_chip    = r_sr[FRAME_W-1];
   assign w_adv     = enable && (r_state inside {SKIP, LMARK, LSPACE, BMARK, BSPACE, STOP});

   ir_run_len u_run_len (
      .clk     (clk),
      .rstn    (rstn),
      .i_start (w_start),
      .i_adv   (w_adv),
      .i_chip  (w_chip),
      .o_len   (w_run_len),
      .o_val   (w_run_val),
      .o_end   (w_run_end)
   );

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_code      = ERR_OK;
      w_bit_vld   = 1'b0;
      w_bit       = 1'b0;
      w_set_rpt   = 1'b0;
      case (r_state)
         IDLE:   if (w_fv_rise) w_state_nxt = SKIP;
         SKIP:   if (w_adv && w_chip) w_state_nxt = LMARK;
         LMARK:  if (w_run_end) begin
            if (in_range(w_run_len, LEAD_MIN, LEAD_MAX)) w_state_nxt = LSPACE;
            else begin w_state_nxt = OUT; w_code = ERR_LEADER; end
         end
         LSPACE: if (w_run_end) begin
            if (in_range(w_run_len, SPN_MIN, SPN_MAX)) w_state_nxt = BMARK;
            else if (in_range(w_run_len, SPR_MIN, SPR_MAX)) begin
               w_state_nxt = STOP;
               w_set_rpt   = 1'b1;
            end else begin w_state_nxt = OUT; w_code = ERR_LEADER; end
         end
         BMARK:  if (w_run_end) begin
            if (in_range(w_run_len, BMARK_MIN, BMARK_MAX)) w_state_nxt = BSPACE;
            else begin w_state_nxt = OUT; w_code = ERR_TIMING; end
         end
         BSPACE: if (w_run_end) begin
            if (in_range(w_run_len, BIT0_MIN, BIT0_MAX)) begin
               w_bit_vld = 1'b1;
               w_bit     = 1'b0;
            end else if (in_range(w_run_len, BIT1_MIN, BIT1_MAX)) begin
               w_bit_vld = 1'b1;
               w_bit     = 1'b1;
            end else begin w_state_nxt = OUT; w_code = ERR_TIMING; end
            if (w_bit_vld) w_state_nxt = (r_nbits == 6'd31) ? STOP : BMARK;
         end
         // A stop mark ending validly leaves the run at 0; any later 1 is a timing error.
         STOP:   if (w_run_end) begin
            if (!w_run_val || !in_range(w_run_len, STOP_MIN, STOP_MAX)) begin
               w_state_nxt = OUT;
               w_code      = ERR_TIMING;
            end
         end
         CHECK:  if (enable) begin
            w_state_nxt = OUT;
            if (!r_is_rpt && (r_data[31:24] != ~r_data[23:16])) w_code = ERR_CHKSUM;
         end
         OUT:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // The chip after the last frame chip is an implicit 0 that closes any open mark.
      if (w_adv && (r_left == '0) && (w_state_nxt != OUT)) begin
         if (w_state_nxt == STOP) w_state_nxt = CHECK;
         else if (w_state_nxt == SKIP) begin w_state_nxt = OUT; w_code = ERR_EMPTY; end
         else begin w_state_nxt = OUT; w_code = ERR_TRUNC; end
      end
   end

   assign w_load = (w_state_nxt == OUT) && (r_state != OUT);
   assign w_upd  = (r_state == CHECK) && w_load && !r_is_rpt && (w_code == ERR_OK);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // Edge register comes out of reset as 1 so a level held high is not seen as an edge.
         r_fv_d    <= 1'b1;
         r_overrun <= 1'b0;
         r_sr      <= '0;
         r_left    <= '0;
         r_data    <= '0;
         r_nbits   <= '0;
         r_is_rpt  <= 1'b0;
         r_addr    <= '0;
         r_cmd     <= '0;
         r_ext     <= 1'b0;
         r_rpt     <= 1'b0;
         r_err     <= ERR_OK;
      end else begin
         r_fv_d    <= frame_valid;
         r_overrun <= w_fv_rise && (r_state != IDLE);
         if (w_start) begin
            r_sr     <= frame;
            r_left   <= CNT_W'(FRAME_W);
            r_data   <= '0;
            r_nbits  <= '0;
            r_is_rpt <= 1'b0;
         end else if (w_adv) begin
            r_sr <= {r_sr[FRAME_W-2:0], 1'b0};
            if (r_left != '0) r_left <= r_left - CNT_W'(1);
         end
         if (w_bit_vld) begin
            r_data  <= {w_bit, r_data[31:1]};
            r_nbits <= r_nbits + 6'd1;
         end
         if (w_set_rpt) r_is_rpt <= 1'b1;
         if (w_load) begin
            r_err <= w_code;
            r_rpt <= r_is_rpt && (w_code == ERR_OK);
         end
         if (w_upd) begin
            r_addr <= r_data[15:0];
            r_cmd  <= r_data[23:16];
            r_ext  <= (r_data[15:8] != ~r_data[7:0]);
         end
      end
   end

   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == OUT);
   assign overrun   = r_overrun;
   assign addr      = r_addr;
   assign cmd       = r_cmd;
   assign addr_ext  = r_ext;
   assign rpt       = r_rpt;
   assign err       = r_err;

endmodule
